// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-stage constants and the next-pc source encoding for pc_sequencer.
package pc_sequencer_pkg;

  localparam logic [31:0] PC_RESET    = 32'h0000_3000;
  localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
  localparam logic [31:0] IM_LO       = 32'h0000_3000;
  localparam logic [31:0] IM_HI       = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL    = 5'd4;
  localparam logic [4:0]  EXC_NONE    = 5'd0;

  typedef enum logic [2:0] {
    PC_SEL_EXC,
    PC_SEL_ERET,
    PC_SEL_HOLD,
    PC_SEL_BRANCH,
    PC_SEL_PEND,
    PC_SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_fetch_addr_check.sv
// Combinational fetch address check: misaligned or outside the instruction
// memory window raises an address-error-on-load.
module fetch_addr_check
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  output logic        adel,
  output logic [4:0]  exc_code
);

  always_comb begin
    adel     = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    exc_code = adel ? EXC_ADEL : EXC_NONE;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with exception/eret entry, stall hold, a one-entry pending
// redirect buffer for branches that arrive during a stall, and delay-slot flag.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        jump_in_d,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] instr_out,
  output logic        adel,
  output logic [4:0]  exc_code,
  output logic        bd
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_valid_q, pend_valid_d;
  logic        bd_q, bd_d;
  pc_sel_e     pc_sel;

  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (exc_req)           pc_sel = PC_SEL_EXC;
    else if (eret_req)     pc_sel = PC_SEL_ERET;
    else if (stall)        pc_sel = PC_SEL_HOLD;
    else if (br_valid)     pc_sel = PC_SEL_BRANCH;
    else if (pend_valid_q) pc_sel = PC_SEL_PEND;
  end

  always_comb begin
    pc_d          = pc_q + 32'd4;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    bd_d          = bd_q;
    unique case (pc_sel)
      PC_SEL_EXC: begin
        pc_d         = EXC_HANDLER;
        pend_valid_d = 1'b0;
        bd_d         = 1'b0;
      end
      PC_SEL_ERET: begin
        pc_d         = epc;
        pend_valid_d = 1'b0;
        bd_d         = 1'b0;
      end
      PC_SEL_HOLD: begin
        pc_d = pc_q;
        // latest redirect seen during a stall wins
        if (br_valid) begin
          pend_valid_d  = 1'b1;
          pend_target_d = br_target;
        end
      end
      PC_SEL_BRANCH: begin
        pc_d         = br_target;
        pend_valid_d = 1'b0;
        bd_d         = jump_in_d;
      end
      PC_SEL_PEND: begin
        pc_d         = pend_target_q;
        pend_valid_d = 1'b0;
        bd_d         = jump_in_d;
      end
      default: begin
        bd_d = jump_in_d;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      bd_q          <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      bd_q          <= bd_d;
    end
  end

  fetch_addr_check u_addr_check (
    .pc       (pc_q),
    .adel     (adel),
    .exc_code (exc_code)
  );

  assign pc        = pc_q;
  assign bd        = bd_q;
  assign instr_out = adel ? 32'h0 : instr_in;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios plus randomized traffic for pc_sequencer, checked against
// a rule-level reference model of the fetch PC.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, br_valid, jump_in_d, exc_req, eret_req;
  logic [31:0] br_target, epc, instr_in;
  logic [31:0] pc, instr_out;
  logic        adel, bd;
  logic [4:0]  exc_code;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic        m_bd;
  logic [31:0] pend_q[$];

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .jump_in_d (jump_in_d),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .instr_in  (instr_in),
    .pc        (pc),
    .instr_out (instr_out),
    .adel      (adel),
    .exc_code  (exc_code),
    .bd        (bd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_pc = 32'h3000; m_bd = 1'b0; pend_q.delete();
    end else if (exc_req) begin
      m_pc = 32'h4180; m_bd = 1'b0; pend_q.delete();
    end else if (eret_req) begin
      m_pc = epc; m_bd = 1'b0; pend_q.delete();
    end else if (stall) begin
      if (br_valid) begin
        pend_q.delete();
        pend_q.push_back(br_target);
      end
    end else begin
      m_bd = jump_in_d;
      if (br_valid) begin
        m_pc = br_target;
        pend_q.delete();
      end else if (pend_q.size() > 0) begin
        m_pc = pend_q.pop_front();
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // one clock: model follows the edge, then all outputs are compared
  task automatic step();
    logic m_adel;
    @(posedge clk);
    model_edge();
    #1;
    instr_in = $urandom;
    #1;
    m_adel = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
    check("pc", pc, m_pc);
    check("bd", {31'b0, bd}, {31'b0, m_bd});
    check("adel", {31'b0, adel}, {31'b0, m_adel});
    check("exc_code", {27'b0, exc_code}, m_adel ? 32'd4 : 32'd0);
    check("instr_out", instr_out, m_adel ? 32'h0 : instr_in);
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; br_valid = 0; jump_in_d = 0;
    exc_req = 0; eret_req = 0;
  endtask

  logic [31:0] bad_targets[3];

  initial begin
    idle_inputs();
    br_target = 0; epc = 0; instr_in = 0;
    m_pc = 0; m_bd = 0;

    // reset then idle advance
    reset = 1;
    step();
    check("rst_pc", pc, 32'h3000);
    check("rst_adel", {31'b0, adel}, 32'd0);
    check("rst_instr", instr_out, instr_in);
    reset = 0;
    step(); check("seq_pc1", pc, 32'h3004);
    step(); check("seq_pc2", pc, 32'h3008);
    step(); check("seq_pc3", pc, 32'h300C);
    step(); check("seq_pc4", pc, 32'h3010);

    // branch with delay slot
    br_valid = 1; br_target = 32'h3100; jump_in_d = 1;
    step(); check("br_pc", pc, 32'h3100); check("br_bd", {31'b0, bd}, 32'd1);
    br_valid = 0; jump_in_d = 0;
    step(); check("br_next_pc", pc, 32'h3104); check("br_next_bd", {31'b0, bd}, 32'd0);

    // redirect during stall becomes pending
    stall = 1; br_valid = 1; br_target = 32'h3200;
    step(); check("stall_hold1", pc, 32'h3104);
    br_valid = 0;
    step(); check("stall_hold2", pc, 32'h3104);
    stall = 0;
    step(); check("pend_taken", pc, 32'h3200);
    step(); check("pend_cleared", pc, 32'h3204);

    // exception beats stall and branch; eret returns
    stall = 1; exc_req = 1; br_valid = 1; br_target = 32'h3300;
    step(); check("exc_pc", pc, 32'h4180); check("exc_bd", {31'b0, bd}, 32'd0);
    idle_inputs(); eret_req = 1; epc = 32'h3024;
    step(); check("eret_pc", pc, 32'h3024);
    eret_req = 0;
    step(); check("exc_pend_dropped", pc, 32'h3028);

    // address error targets
    bad_targets[0] = 32'h3002; bad_targets[1] = 32'h2FFC; bad_targets[2] = 32'h7000;
    for (int i = 0; i < 3; i++) begin
      br_valid = 1; br_target = bad_targets[i];
      step();
      check("adel_bad", {31'b0, adel}, 32'd1);
      check("exc_bad", {27'b0, exc_code}, 32'd4);
      check("instr_bad", instr_out, 32'h0);
    end
    br_target = 32'h6FFC;
    step(); check("adel_hi_edge", {31'b0, adel}, 32'd0);
    br_valid = 0;

    // reset during stall discards pending redirect
    stall = 1; br_valid = 1; br_target = 32'h3400;
    step();
    br_valid = 0; reset = 1;
    step(); check("rst_stall_pc", pc, 32'h3000);
    idle_inputs();
    step(); check("rst_pend_gone", pc, 32'h3004);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 99) < 2);
      exc_req   = ($urandom_range(0, 99) < 4);
      eret_req  = ($urandom_range(0, 99) < 4);
      stall     = ($urandom_range(0, 99) < 30);
      br_valid  = ($urandom_range(0, 99) < 25);
      jump_in_d = $urandom_range(0, 1);
      br_target = ($urandom_range(0, 9) == 0) ? $urandom
                : (32'h3000 + ($urandom_range(0, 32'hFFF) << 2));
      epc       = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
